// File: rtl/pipe_skid_buf_pkg.sv
// Shared core definitions for the two-entry skid buffer.
// State encoding is fixed at 2 bits; the unused code is recovered to EMPTY by the FSM.
package pipe_skid_buf_pkg;

    typedef enum logic [1:0] {
        SKB_EMPTY   = 2'd0,
        SKB_ONE     = 2'd1,
        SKB_TWO     = 2'd2,
        SKB_ILLEGAL = 2'd3
    } skb_state_t;

endpackage : pipe_skid_buf_pkg

// File: rtl/pipe_skid_buf_dff_set.sv
// Sync-reset data flop with a synchronous set-to-constant and load enable.
// Reset and set both force the register to set_data; otherwise it loads d_i when enabled.
module dff_set #(
    parameter int            DW       = 32,
    parameter logic [DW-1:0] set_data = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_i,
    input  logic          en_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [DW-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n || set_i) begin
            r_q <= set_data;
        end else if (en_i) begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule : dff_set

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer: ready and valid are decoded from registered state only,
// so a downstream stall never creates a combinational path back to the producer.
module pipe_skid_buf
    import pipe_skid_buf_pkg::*;
#(
    parameter int            DW      = 32,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    skb_state_t    r_state;
    skb_state_t    w_nextState;
    logic          w_push;
    logic          w_pop;
    logic          w_mainEn;
    logic          w_mainFromSkid;
    logic          w_skidEn;
    logic [DW-1:0] w_mainD;
    logic [DW-1:0] w_mainQ;
    logic [DW-1:0] w_skidQ;

    assign in_ready_o  = (r_state != SKB_TWO);
    assign out_valid_o = (r_state != SKB_EMPTY);
    assign out_data_o  = w_mainQ;

    assign w_push = in_valid_i & in_ready_o;
    assign w_pop  = out_valid_o & out_ready_i;

    // Flush takes effect like reset; the data flops see it through their set input.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            r_state <= SKB_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_mainEn       = 1'b0;
        w_mainFromSkid = 1'b0;
        w_skidEn       = 1'b0;
        case (r_state)
            SKB_EMPTY: begin
                if (w_push) begin
                    w_nextState = SKB_ONE;
                    w_mainEn    = 1'b1;
                end
            end
            SKB_ONE: begin
                if (w_push && w_pop) begin
                    w_mainEn = 1'b1;
                end else if (w_push) begin
                    w_nextState = SKB_TWO;
                    w_skidEn    = 1'b1;
                end else if (w_pop) begin
                    w_nextState = SKB_EMPTY;
                end
            end
            SKB_TWO: begin
                if (w_pop) begin
                    w_nextState    = SKB_ONE;
                    w_mainEn       = 1'b1;
                    w_mainFromSkid = 1'b1;
                end
            end
            default: begin
                w_nextState = SKB_EMPTY;
            end
        endcase
    end

    assign w_mainD = w_mainFromSkid ? w_skidQ : in_data_i;

    dff_set #(
        .DW       (DW),
        .set_data (RST_VAL)
    ) u_mainReg (
        .clk   (clk),
        .rst_n (rst_n),
        .set_i (flush_i),
        .en_i  (w_mainEn),
        .d_i   (w_mainD),
        .q_o   (w_mainQ)
    );

    dff_set #(
        .DW       (DW),
        .set_data (RST_VAL)
    ) u_skidReg (
        .clk   (clk),
        .rst_n (rst_n),
        .set_i (flush_i),
        .en_i  (w_skidEn),
        .d_i   (in_data_i),
        .q_o   (w_skidQ)
    );

endmodule : pipe_skid_buf

// File: tb/tb_pipe_skid_buf.sv
// Self-checking bench for pipe_skid_buf: directed scenarios plus a randomized run,
// all compared against a queue model of a two-deep buffer with registered flags.
module tb_pipe_skid_buf;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;

    int            compared   = 0;
    int            mismatched = 0;
    logic [DW-1:0] modelQ[$];

    always #5 clk = ~clk;

    pipe_skid_buf #(
        .DW      (DW),
        .RST_VAL ('0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Model view: ready while fewer than two items are held, valid while any item is held.
    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, ".ready"}, DW'(in_ready_o), DW'(modelQ.size() < 2));
        checkOutput({tag, ".valid"}, DW'(out_valid_o), DW'(modelQ.size() > 0));
        if (modelQ.size() > 0) begin
            checkOutput({tag, ".data"}, out_data_o, modelQ[0]);
        end
    endtask

    // Drives one cycle, checks before the edge, then advances the model at the edge.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r,
                                 input logic f, input string tag, input logic doCheck);
        bit pushOk;
        bit popOk;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = f;
        @(negedge clk);
        if (doCheck) begin
            checkAgainstModel(tag);
        end
        pushOk = v && (modelQ.size() < 2);
        popOk  = r && (modelQ.size() > 0);
        @(posedge clk);
        if (!rst_n || f) begin
            modelQ.delete();
        end else begin
            if (popOk) void'(modelQ.pop_front());
            if (pushOk) modelQ.push_back(d);
        end
        #1;
    endtask

    initial begin
        logic [DW-1:0] pendData;
        bit            holding;
        bit            v;
        bit            r;
        bit            f;

        rst_n       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        @(posedge clk);
        #1;

        // Reset dominates an offered item.
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, "reset", 1'b0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, "reset", 1'b0);
        checkOutput("reset.valid", DW'(out_valid_o), '0);
        checkOutput("reset.ready", DW'(in_ready_o), 32'd1);
        checkOutput("reset.data", out_data_o, '0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, "release", 1'b1);
        checkOutput("release.data", out_data_o, 32'hDEAD_BEEF);
        checkOutput("release.valid", DW'(out_valid_o), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "release.drain", 1'b1);

        // Full-rate streaming: each item visible one cycle after its push.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b1, 1'b0, "stream", 1'b1);
            checkOutput("stream.data", out_data_o, DW'(i));
            checkOutput("stream.ready", DW'(in_ready_o), 32'd1);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "stream.drain", 1'b1);

        // Fill under stall, reject a third item, then drain in order.
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, "stall", 1'b1);
        applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, "stall", 1'b1);
        checkOutput("stall.ready", DW'(in_ready_o), '0);
        checkOutput("stall.head", out_data_o, 32'hA);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, "stall.reject", 1'b1);
        checkOutput("stall.holdA", out_data_o, 32'hA);
        applyStimulus(1'b1, 32'hC, 1'b1, 1'b0, "stall.popA", 1'b1);
        checkOutput("stall.headB", out_data_o, 32'hB);
        applyStimulus(1'b1, 32'hC, 1'b1, 1'b0, "stall.popB", 1'b1);
        checkOutput("stall.headC", out_data_o, 32'hC);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "stall.popC", 1'b1);
        checkOutput("stall.empty", DW'(out_valid_o), '0);

        // Flush while full drops both entries and the simultaneous push.
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, "flush.fill", 1'b1);
        applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, "flush.fill", 1'b1);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b1, "flush", 1'b1);
        checkOutput("flush.valid", DW'(out_valid_o), '0);
        checkOutput("flush.ready", DW'(in_ready_o), 32'd1);
        checkOutput("flush.data", out_data_o, '0);

        // Simultaneous push and pop in ONE replaces the head.
        applyStimulus(1'b1, 32'h5, 1'b0, 1'b0, "pushpop.fill", 1'b1);
        applyStimulus(1'b1, 32'h6, 1'b1, 1'b0, "pushpop", 1'b1);
        checkOutput("pushpop.data", out_data_o, 32'h6);
        checkOutput("pushpop.valid", DW'(out_valid_o), 32'd1);
        checkOutput("pushpop.ready", DW'(in_ready_o), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "pushpop.drain", 1'b1);

        // Random traffic; the producer holds an offered item until it is taken.
        holding  = 1'b0;
        pendData = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!holding) begin
                v        = ($urandom_range(0, 3) != 0);
                pendData = $urandom;
            end else begin
                v = 1'b1;
            end
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 199) == 0);
            holding = v && !(modelQ.size() < 2);
            applyStimulus(v, pendData, r, f, "random", 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_pipe_skid_buf
